// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types for the I2C transaction scheduler slice.
// Engine command encoding and scheduler FSM state enum.
package i2c_pkg;

    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_READ  = 2'd2,
        CMD_STOP  = 2'd3
    } eng_cmd_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_START,
        S_ADDR,
        S_WR,
        S_RD,
        S_STOP,
        S_DONE
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin picker with an internal rotating pointer.
// Ports: clk, reset (async, active-high), req_i, enable_i in;
//        gnt_o one-hot winner (combinational) out.
module rr_arbiter
    import i2c_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req_i,
    input  logic            enable_i,
    output logic [NREQ-1:0] gnt_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] win_idx;
    logic [PW-1:0] jw;
    logic          found;

    // Scan starting at the pointer and wrapping; first set bit wins.
    always_comb begin
        int j;
        j       = 0;
        jw      = '0;
        gnt_o   = '0;
        win_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            jw = PW'(j);
            if (!found && req_i[jw]) begin
                found      = 1'b1;
                gnt_o[jw]  = 1'b1;
                win_idx    = jw;
            end
        end
    end

    always_comb begin
        if (win_idx == PW'(NREQ - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = win_idx + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (enable_i && found) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/i2c_txn_scheduler.sv
// i2c_txn_scheduler: shares one byte-level I2C engine among NREQ clients,
// granting round-robin and sequencing START, addr+R/W, LEN bytes, STOP.
// Ports: client side req/req_addr/req_rw/req_len/wr_data in;
//        grant/wr_req/rd_data/rd_valid/done/nack out.
//        Engine side eng_cmd/eng_cmd_valid/eng_tx/eng_mack out;
//        eng_cmd_ready/eng_done/eng_rx/eng_nack in.
module i2c_txn_scheduler
    import i2c_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int LEN_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [7*NREQ-1:0]     req_addr,
    input  logic [NREQ-1:0]       req_rw,
    input  logic [LEN_W*NREQ-1:0] req_len,
    input  logic [7:0]            wr_data,
    output logic [NREQ-1:0]       grant,
    output logic                  wr_req,
    output logic [7:0]            rd_data,
    output logic                  rd_valid,
    output logic                  done,
    output logic                  nack,
    output logic [1:0]            eng_cmd,
    output logic                  eng_cmd_valid,
    input  logic                  eng_cmd_ready,
    output logic [7:0]            eng_tx,
    output logic                  eng_mack,
    input  logic                  eng_done,
    input  logic [7:0]            eng_rx,
    input  logic                  eng_nack
);

    state_e           state_q;
    logic [NREQ-1:0]  grant_q;
    logic [6:0]       addr_q;
    logic             rw_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_dec;
    logic             nflag_q;
    logic             prep_q;
    eng_cmd_e         cmd_q;
    logic             valid_q;
    logic [7:0]       tx_q;
    logic             mack_q;
    logic             wr_req_q;
    logic [7:0]       rd_data_q;
    logic             rd_valid_q;
    logic             done_q;
    logic             nack_q;

    logic [NREQ-1:0]  win;
    logic             arb_en;
    logic [6:0]       sel_addr;
    logic             sel_rw;
    logic [LEN_W-1:0] sel_len;
    logic             cmd_fin;

    assign arb_en = (state_q == S_ARB);

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req_i   (req),
        .enable_i(arb_en),
        .gnt_o   (win)
    );

    always_comb begin
        sel_addr = '0;
        sel_rw   = 1'b0;
        sel_len  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win[i]) begin
                sel_addr = req_addr[7*i +: 7];
                sel_rw   = req_rw[i];
                sel_len  = req_len[LEN_W*i +: LEN_W];
            end
        end
    end

    assign cnt_dec = cnt_q - LEN_W'(1);
    // Completion only counts once our command has been accepted.
    assign cmd_fin = eng_done && !valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            addr_q     <= '0;
            rw_q       <= 1'b0;
            cnt_q      <= '0;
            nflag_q    <= 1'b0;
            prep_q     <= 1'b0;
            cmd_q      <= CMD_START;
            valid_q    <= 1'b0;
            tx_q       <= '0;
            mack_q     <= 1'b0;
            wr_req_q   <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            nack_q     <= 1'b0;
        end else begin
            wr_req_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            nack_q     <= 1'b0;
            if (valid_q && eng_cmd_ready) begin
                valid_q <= 1'b0;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (|req) begin
                        state_q <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (|win) begin
                        grant_q <= win;
                        addr_q  <= sel_addr;
                        rw_q    <= sel_rw;
                        cnt_q   <= sel_len;
                        nflag_q <= 1'b0;
                        cmd_q   <= CMD_START;
                        mack_q  <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= S_START;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_START: begin
                    if (cmd_fin) begin
                        cmd_q   <= CMD_WRITE;
                        tx_q    <= {addr_q, rw_q};
                        valid_q <= 1'b1;
                        state_q <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (cmd_fin) begin
                        if (eng_nack || cnt_q == '0) begin
                            nflag_q <= eng_nack;
                            cmd_q   <= CMD_STOP;
                            valid_q <= 1'b1;
                            state_q <= S_STOP;
                        end else if (rw_q) begin
                            cmd_q   <= CMD_READ;
                            mack_q  <= (cnt_q == LEN_W'(1));
                            valid_q <= 1'b1;
                            state_q <= S_RD;
                        end else begin
                            wr_req_q <= 1'b1;
                            prep_q   <= 1'b1;
                            state_q  <= S_WR;
                        end
                    end
                end
                S_WR: begin
                    // wr_data answers the wr_req pulse within the same cycle.
                    if (prep_q) begin
                        prep_q  <= 1'b0;
                        tx_q    <= wr_data;
                        cmd_q   <= CMD_WRITE;
                        valid_q <= 1'b1;
                    end else if (cmd_fin) begin
                        cnt_q <= cnt_dec;
                        if (eng_nack || cnt_dec == '0) begin
                            nflag_q <= eng_nack;
                            cmd_q   <= CMD_STOP;
                            valid_q <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            wr_req_q <= 1'b1;
                            prep_q   <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    if (cmd_fin) begin
                        rd_data_q  <= eng_rx;
                        rd_valid_q <= 1'b1;
                        cnt_q      <= cnt_dec;
                        if (cnt_dec == '0) begin
                            cmd_q   <= CMD_STOP;
                            mack_q  <= 1'b0;
                            valid_q <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            cmd_q   <= CMD_READ;
                            mack_q  <= (cnt_dec == LEN_W'(1));
                            valid_q <= 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    if (cmd_fin) begin
                        done_q  <= 1'b1;
                        nack_q  <= nflag_q;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    grant_q <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign grant         = grant_q;
    assign wr_req        = wr_req_q;
    assign rd_data       = rd_data_q;
    assign rd_valid      = rd_valid_q;
    assign done          = done_q;
    assign nack          = nack_q;
    assign eng_cmd       = cmd_q;
    assign eng_cmd_valid = valid_q;
    assign eng_tx        = tx_q;
    assign eng_mack      = mack_q;

endmodule
